// File: rtl/misaligned_load_unit_if.sv
// misaligned_load_unit_if: request, data-memory and response signals of the load unit.
interface misaligned_load_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_func3;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_busywait;
    logic [31:0]           mem_readdata;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_fault;

    modport master (
        output req_valid, req_addr, req_func3, req_tag, mem_busywait, mem_readdata,
        input  req_ready, mem_read, mem_addr, resp_valid, resp_data, resp_tag, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_func3, req_tag, mem_busywait, mem_readdata,
        output req_ready, mem_read, mem_addr, resp_valid, resp_data, resp_tag, resp_fault
    );
endinterface

// File: rtl/misaligned_load_unit.sv
// misaligned_load_unit: RV32 load unit fetching one or two aligned words, then merging and extending.
// Define MISALIGNED_SPLIT_EN to perform word-crossing loads; otherwise they fault with no memory access.
module misaligned_load_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH = 5,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst_n,
    misaligned_load_unit_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

    state_t                state, state_n;
    logic                  started, fault_r, accept, done, expired, legal_in;
    logic [ADDR_WIDTH-1:0] addr_r, base;
    logic [2:0]            func3_r;
    logic [TAG_WIDTH-1:0]  tag_r;
    logic [31:0]           word0, word1, merged, ext;
    logic [CW-1:0]         cnt;
`ifdef MISALIGNED_SPLIT_EN
    logic                  split_r;
`else
    logic                  split_in;
`endif

    function automatic logic is_legal(input logic [2:0] f);
        return f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic logic is_split(input logic [2:0] f, input logic [1:0] off);
        return (f[1:0] == 2'b01 && off == 2'd3) || (f == 3'b010 && off != 2'd0);
    endfunction

    assign accept   = bus.req_valid && bus.req_ready;
    assign legal_in = is_legal(bus.req_func3);
    assign done     = !bus.mem_busywait;
    assign expired  = bus.mem_busywait && cnt == CW'(TIMEOUT - 1);
`ifdef MISALIGNED_SPLIT_EN
    assign split_r  = is_split(func3_r, addr_r[1:0]);
`else
    assign split_in = is_split(bus.req_func3, bus.req_addr[1:0]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
`ifdef MISALIGNED_SPLIT_EN
            IDLE: state_n = !accept ? IDLE : legal_in ? RD0 : RESP;
            RD0:  state_n = done ? (split_r ? RD1 : RESP) : expired ? RESP : RD0;
            RD1:  state_n = (done || expired) ? RESP : RD1;
`else
            IDLE: state_n = !accept ? IDLE : (legal_in && !split_in) ? RD0 : RESP;
            RD0:  state_n = (done || expired) ? RESP : RD0;
`endif
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            fault_r <= 1'b0;
            addr_r  <= '0;
            func3_r <= '0;
            tag_r   <= '0;
            word0   <= '0;
            word1   <= '0;
            cnt     <= '0;
        end else begin
            started <= 1'b1;
            cnt     <= (state_n != state) ? '0 : bus.mem_busywait ? cnt + CW'(1) : cnt;
            if (accept) begin
                addr_r  <= bus.req_addr;
                func3_r <= bus.req_func3;
                tag_r   <= bus.req_tag;
                word1   <= '0;
`ifdef MISALIGNED_SPLIT_EN
                fault_r <= !legal_in;
`else
                fault_r <= !legal_in || split_in;
`endif
            end
            if (state == RD0 && done)
                word0 <= bus.mem_readdata;
`ifdef MISALIGNED_SPLIT_EN
            if (state == RD1 && done)
                word1 <= bus.mem_readdata;
`endif
            if ((state == RD0 || state == RD1) && expired)
                fault_r <= 1'b1;
        end
    end

    // word1 stays zero for single-word loads, so the merge is the same shift either way
    always_comb begin
        base   = {addr_r[ADDR_WIDTH-1:2], 2'b00};
        merged = 32'({word1, word0} >> {addr_r[1:0], 3'b000});
        ext    = func3_r == 3'b000 ? {{24{merged[7]}}, merged[7:0]} :
                 func3_r == 3'b100 ? {24'h0, merged[7:0]} :
                 func3_r == 3'b001 ? {{16{merged[15]}}, merged[15:0]} :
                 func3_r == 3'b101 ? {16'h0, merged[15:0]} : merged;
        bus.req_ready  = started && state == IDLE;
        bus.mem_read   = state == RD0 || state == RD1;
`ifdef MISALIGNED_SPLIT_EN
        bus.mem_addr   = state == RD1 ? base + ADDR_WIDTH'(4) : base;
`else
        bus.mem_addr   = base;
`endif
        bus.resp_valid = state == RESP;
        bus.resp_fault = state == RESP && fault_r;
        bus.resp_data  = (state == RESP && !fault_r) ? ext : '0;
        bus.resp_tag   = tag_r;
    end
endmodule

// File: tb/tb_misaligned_load_unit.sv
// tb_misaligned_load_unit: directed load vectors plus wait-state, timeout and mid-operation reset sequences.
module tb_misaligned_load_unit;
    localparam int TIMEOUT = 64;
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        fault;
        int          lat;
        int          reads;
        logic [31:0] a0;
        logic [31:0] a1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wait_req = 0;
    bit   stuck = 1'b0;
    int   waited = 0;
    vec_t v[16];

    misaligned_load_unit_if #(.ADDR_WIDTH(32), .TAG_WIDTH(5)) bus();
    misaligned_load_unit #(.ADDR_WIDTH(32), .TAG_WIDTH(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h4433_2211;
            32'h0000_0104: return 32'h8877_6655;
            32'h0000_0108: return 32'hCCBB_AA99;
            32'hFFFF_FFFC: return 32'hDEAD_BEEF;
            32'h0000_0000: return 32'h0302_0100;
            default:       return 32'h0;
        endcase
    endfunction

    assign bus.mem_readdata = mem_word(bus.mem_addr);
    assign bus.mem_busywait = stuck || waited < wait_req;
    always @(posedge clk) waited <= (bus.mem_read && bus.mem_busywait) ? waited + 1 : 0;

    function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] tag,
                                input logic [31:0] data, input logic fault, input int lat,
                                input int reads, input logic [31:0] a0, input logic [31:0] a1);
        vec_t r;
        r.addr = addr; r.f3 = f3; r.tag = tag; r.data = data; r.fault = fault;
        r.lat = lat; r.reads = reads; r.a0 = a0; r.a1 = a1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns once the response is seen or the cycle budget runs out (lat=0).
    task automatic do_req(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] tag,
                          output logic [31:0] d, output logic f, output logic [4:0] t,
                          output int lat, output int reads, output int high,
                          output logic [31:0] a0, output logic [31:0] a1);
        int n = 0;
        d = '0; f = 1'b0; t = '0; lat = 0; reads = 0; high = 0; a0 = '0; a1 = '0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_func3 = f3;
        bus.req_tag   = tag;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (bus.mem_read) high++;
            if (bus.mem_read && !bus.mem_busywait) begin
                if (reads == 0) a0 = bus.mem_addr;
                else a1 = bus.mem_addr;
                reads++;
            end
            if (bus.resp_valid) begin
                lat = k;
                d = bus.resp_data;
                f = bus.resp_fault;
                t = bus.resp_tag;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] d, a0, a1;
        logic        f;
        logic [4:0]  t;
        int          lat, reads, high;
        bit          found, seen;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_func3 = '0;
        bus.req_tag   = '0;
        v[0]  = mk(32'h107, 3'b000, 5'd1,  32'hFFFFFF88, 1'b0, 2, 1, 32'h104, 32'h0);
        v[1]  = mk(32'h107, 3'b100, 5'd2,  32'h00000088, 1'b0, 2, 1, 32'h104, 32'h0);
        v[2]  = mk(32'h102, 3'b001, 5'd3,  32'h00004433, 1'b0, 2, 1, 32'h100, 32'h0);
        v[3]  = mk(32'h100, 3'b010, 5'd4,  32'h44332211, 1'b0, 2, 1, 32'h100, 32'h0);
        v[4]  = mk(32'h106, 3'b001, 5'd5,  32'hFFFF8877, 1'b0, 2, 1, 32'h104, 32'h0);
        v[5]  = mk(32'h105, 3'b101, 5'd6,  32'h00007766, 1'b0, 2, 1, 32'h104, 32'h0);
        v[6]  = mk(32'h101, 3'b000, 5'd7,  32'h00000022, 1'b0, 2, 1, 32'h100, 32'h0);
        v[7]  = mk(32'h10B, 3'b000, 5'd8,  32'hFFFFFFCC, 1'b0, 2, 1, 32'h108, 32'h0);
        v[8]  = mk(32'h100, 3'b011, 5'd9,  32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        v[9]  = mk(32'h104, 3'b111, 5'd10, 32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        v[10] = SPLIT ? mk(32'h102, 3'b010, 5'd11, 32'h66554433, 1'b0, 3, 2, 32'h100, 32'h104)
                      : mk(32'h102, 3'b010, 5'd11, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        v[11] = SPLIT ? mk(32'h107, 3'b001, 5'd12, 32'hFFFF9988, 1'b0, 3, 2, 32'h104, 32'h108)
                      : mk(32'h107, 3'b001, 5'd12, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        v[12] = SPLIT ? mk(32'h107, 3'b101, 5'd13, 32'h00009988, 1'b0, 3, 2, 32'h104, 32'h108)
                      : mk(32'h107, 3'b101, 5'd13, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        v[13] = SPLIT ? mk(32'hFFFFFFFE, 3'b010, 5'd14, 32'h0100DEAD, 1'b0, 3, 2, 32'hFFFFFFFC, 32'h0)
                      : mk(32'hFFFFFFFE, 3'b010, 5'd14, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        v[14] = SPLIT ? mk(32'h103, 3'b010, 5'd15, 32'h77665544, 1'b0, 3, 2, 32'h100, 32'h104)
                      : mk(32'h103, 3'b010, 5'd15, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        v[15] = mk(32'h100, 3'b101, 5'd16, 32'h00002211, 1'b0, 2, 1, 32'h100, 32'h0);

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_fault", bus.resp_fault, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_tag", bus.resp_tag, 0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", bus.req_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", bus.req_ready, 1);

        foreach (v[i]) begin
            do_req(v[i].addr, v[i].f3, v[i].tag, d, f, t, lat, reads, high, a0, a1);
            chk($sformatf("v%0d_data", i), d, v[i].data);
            chk($sformatf("v%0d_fault", i), f, v[i].fault);
            chk($sformatf("v%0d_tag", i), t, v[i].tag);
            chk($sformatf("v%0d_latency", i), lat, v[i].lat);
            chk($sformatf("v%0d_reads", i), reads, v[i].reads);
            if (v[i].reads >= 1) chk($sformatf("v%0d_addr0", i), a0, v[i].a0);
            if (v[i].reads >= 2) chk($sformatf("v%0d_addr1", i), a1, v[i].a1);
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i), bus.resp_valid, 0);
            chk($sformatf("v%0d_ready_back", i), bus.req_ready, 1);
        end

        wait_req = 3;
        do_req(32'h100, 3'b010, 5'd3, d, f, t, lat, reads, high, a0, a1);
        chk("wait_data", d, 32'h44332211);
        chk("wait_latency", lat, 5);
        chk("wait_read_cycles", high, 4);
        wait_req = 0;
        @(negedge clk);

        stuck = 1'b1;
        do_req(32'h100, 3'b010, 5'h1A, d, f, t, lat, reads, high, a0, a1);
        chk("timeout_read_cycles", high, TIMEOUT);
        chk("timeout_latency", lat, TIMEOUT + 1);
        chk("timeout_fault", f, 1);
        chk("timeout_data", d, 0);
        chk("timeout_tag", t, 5'h1A);
        stuck = 1'b0;
        @(negedge clk);
        chk("timeout_ready_back", bus.req_ready, 1);

        wait_req = 5;
        bus.req_valid = 1'b1;
        bus.req_addr  = SPLIT ? 32'h102 : 32'h100;
        bus.req_func3 = 3'b010;
        bus.req_tag   = 5'd9;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (bus.mem_read && bus.mem_addr == (SPLIT ? 32'h104 : 32'h100)) found = 1'b1;
            else @(negedge clk);
        end
        chk("midrst_read_reached", found, 1);
        rst_n = 1'b0;
        #1 chk("midrst_read_drop", bus.mem_read, 0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) rst_n = 1'b1;
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("midrst_no_resp", seen, 0);
        wait_req = 0;
        do_req(32'h100, 3'b010, 5'd21, d, f, t, lat, reads, high, a0, a1);
        chk("postrst_data", d, 32'h44332211);
        chk("postrst_latency", lat, 2);
        chk("postrst_tag", t, 5'd21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/misaligned_load_unit.md
# misaligned_load_unit

Parametrised load-data unit for the RV32IM MEM stage. It generalises the combinational FUNC3 sign/zero-extension stage into a sequential unit that:
- accepts a byte address and FUNC3,
- fetches one or two aligned words from data memory over a busywait handshake,
- merges and extends the bytes,
- returns a single-cycle response with the destination tag.

It also detects illegal FUNC3 and memory timeouts.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width; memory words are 32-bit, word-aligned.
- TAG_WIDTH, 5, width of the destination-register tag carried request→response.
- TIMEOUT, 64, consecutive MEM_BUSYWAIT-high cycles in one read before abort (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  load request valid.
- REQ_READY  out  1  unit can accept; a request is accepted on an edge with REQ_VALID & REQ_READY.
- REQ_ADDR  in  ADDR_WIDTH  byte address.
- REQ_FUNC3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
- REQ_TAG  in  TAG_WIDTH  destination tag.
- MEM_READ  out  1  memory read strobe, registered.
- MEM_ADDR  out  ADDR_WIDTH  word address, low 2 bits always 0.
- MEM_BUSYWAIT  in  1  high = memory not done; MEM_READ & !MEM_BUSYWAIT at an edge completes the read.
- MEM_READDATA  in  32  read word, valid when the read completes.
- RESP_VALID  out  1  one-cycle response pulse.
- RESP_DATA  out  32  extended load result; 0 when faulted.
- RESP_TAG  out  TAG_WIDTH  tag of the responding request.
- RESP_FAULT  out  1  illegal FUNC3, misalignment (macro off) or timeout.

## Operation
- States: IDLE, RD0, RD1, RESP.
- IDLE: REQ_READY=1.
  - On accept, latch addr, func3 and tag; off = addr[1:0].
  - Illegal func3 → RESP with fault; no memory access.
  - Otherwise → RD0 with MEM_ADDR = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Split condition: (LH/LHU with off=3) or (LW with off≠0).
- RD0: MEM_READ=1.
  - On completion, capture word0.
  - Go to RD1 if split, else to RESP.
- RD1: MEM_READ=1, MEM_ADDR = word0 address + 4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0x00000000). On completion, capture word1 → RESP.
- Merge: {word1, word0} >> (8·off). Word1 is treated as 0 when the access does not split. Take the low 32 bits.
- Extend:
  - LB: sign-extend bit 7.
  - LBU: zero-extend from 8 bits.
  - LH: sign-extend bit 15.
  - LHU: zero-extend from 16 bits.
  - LW: pass through.
- Timeout: the wait counter clears on entry to RD0 and RD1 and increments each cycle MEM_BUSYWAIT=1. When it reaches TIMEOUT:
  - drop MEM_READ,
  - go to RESP with RESP_FAULT=1 and RESP_DATA=0.
- RESP: RESP_VALID=1 for exactly one cycle, REQ_READY=0, then IDLE. There is no response backpressure.

## Timing
- Reset (RESET low, asynchronous): state IDLE.
  - REQ_READY, MEM_READ, RESP_VALID and RESP_FAULT are 0.
  - MEM_ADDR, RESP_DATA and RESP_TAG are 0.
  - REQ_READY rises on the first edge after release.
- Reset mid-operation: MEM_READ falls immediately and no response is ever issued for the in-flight request.
- Latency, accept edge to RESP_VALID cycle, zero wait states:
  - aligned: 2 cycles,
  - split: 3 cycles,
  - illegal func3: 1 cycle.
  - Add 1 cycle per busywait cycle.
- MEM_READ and MEM_ADDR stay constant through one read.
- Between RD0 and RD1, MEM_READ stays high while MEM_ADDR changes on the completion edge.
- A request presented while REQ_READY=0 is ignored; the requester holds it.
- Timeout with TIMEOUT=N: MEM_READ is high for N cycles; RESP_VALID follows in the next cycle.

## Configuration
- MISALIGNED_SPLIT_EN defined: split accesses are performed as above.
- MISALIGNED_SPLIT_EN undefined:
  - any access meeting the split condition goes IDLE→RESP with RESP_FAULT=1, RESP_DATA=0 and no MEM_READ;
  - state RD1 is not synthesised;
  - LB/LBU at any offset and LH/LHU at offsets 0–2 behave identically in both builds.

## Test plan
Memory contents: [0x100]=0x44332211, [0x104]=0x88776655, [0x108]=0xCCBBAA99; zero wait unless stated.
- LB @0x107 → 0xFFFFFF88; LBU @0x107 → 0x00000088; LH @0x102 → 0x00004433. Each makes one MEM_READ and responds at accept+2.
- LW @0x102 (macro on) → MEM_ADDR 0x100 then 0x104, RESP 0x66554433 at accept+3. LH @0x107 → 0xFFFF9988; LHU @0x107 → 0x00009988.
- LW @0xFFFFFFFE (macro on) → MEM_ADDR 0xFFFFFFFC then 0x00000000.
- FUNC3=011 @0x100 → RESP_FAULT=1, RESP_DATA=0 at accept+1, no MEM_READ. With the macro off, LW @0x102 gives the same result.
- MEM_BUSYWAIT stuck high, TIMEOUT=64 → MEM_READ high 64 cycles, then RESP_FAULT=1, RESP_TAG=request tag, REQ_READY back to 1.
- RESET low during RD1 of LW @0x102 → MEM_READ=0 immediately, no RESP_VALID. After release, LW @0x100 → 0x44332211.
